// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle for the iterative multiply/divide unit.
// Signal names match the unit's port list so the bundle maps one-to-one onto
// the execute-stage wiring.
//   req_*   : request handshake (valid/ready), funct3 op, operands, tag
//   kill_i  : pipeline flush
//   resp_*  : response handshake (valid/ready), result and tag
//   busy_o  : unit not idle
// master = execute stage (requester), slave = mdu_iter.
interface mdu_iter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [2:0]        req_op_i;
  logic [XLEN-1:0]   req_a_i;
  logic [XLEN-1:0]   req_b_i;
  logic [TAG_W-1:0]  req_tag_i;
  logic              kill_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [XLEN-1:0]   result_o;
  logic [TAG_W-1:0]  resp_tag_o;
  logic              busy_o;

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, kill_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, result_o, resp_tag_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, kill_i, resp_ready_i,
    output req_ready_o, resp_valid_o, result_o, resp_tag_o, busy_o
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M/RV64M multiply/divide unit.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : request handshake + op/operands/tag, kill, response
//                   handshake + result/tag, busy
// MUL retires MUL_STEP multiplier bits per cycle (XLEN/MUL_STEP cycles),
// DIV retires DIV_STEP quotient bits per cycle (XLEN/DIV_STEP cycles) with a
// restoring algorithm on magnitudes. Divide-by-zero and signed overflow
// complete one cycle after accept.
// Optional macro MDU_EARLY_OUT_EN: multiply finishes as soon as the remaining
// multiplier magnitude bits are zero (at least one iteration).
module mdu_iter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 4,
  parameter int unsigned DIV_STEP = 1,
  parameter int unsigned TAG_W    = 5
) (
  input logic     clk_i,
  input logic     rst_ni,
  mdu_iter_if.slave bus
);

  localparam int unsigned NM = XLEN / MUL_STEP;
  localparam int unsigned ND = XLEN / DIV_STEP;
  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned W2 = 2 * XLEN;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              neg_q, neg_d;     // product / quotient negation
  logic              sa_q, sa_d;       // dividend sign (remainder sign)
  logic [XLEN-1:0]   result_q, result_d;
  // Shared datapath registers:
  //   MUL: sh = multiplier (shifts right), wide = multiplicand (shifts left),
  //        acc = running product
  //   DIV: sh = dividend shifting out / quotient shifting in,
  //        wide[XLEN-1:0] = divisor, acc[XLEN-1:0] = partial remainder
  logic [XLEN-1:0]   sh_q, sh_d;
  logic [W2-1:0]     wide_q, wide_d;
  logic [W2-1:0]     acc_q, acc_d;

  // ---------------- request decode ----------------
  logic              a_signed, b_signed, sa_in, sb_in;
  logic [XLEN-1:0]   ma_in, mb_in;
  logic              is_div_in, div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;
  logic              accept;

  always_comb begin
    a_signed = bus.req_op_i[2] ? ~bus.req_op_i[0]
                               : (bus.req_op_i[1:0] == 2'b01 || bus.req_op_i[1:0] == 2'b10);
    b_signed = bus.req_op_i[2] ? ~bus.req_op_i[0] : (bus.req_op_i[1:0] == 2'b01);
    sa_in    = a_signed & bus.req_a_i[XLEN-1];
    sb_in    = b_signed & bus.req_b_i[XLEN-1];
    ma_in    = sa_in ? -bus.req_a_i : bus.req_a_i;
    mb_in    = sb_in ? -bus.req_b_i : bus.req_b_i;
    is_div_in = bus.req_op_i[2];
    div_zero = (bus.req_b_i == '0);
    div_ovf  = ~bus.req_op_i[0] && (bus.req_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
               (bus.req_b_i == '1);
    if (div_zero) begin
      special_res = bus.req_op_i[1] ? bus.req_a_i : '1;
    end else begin
      special_res = bus.req_op_i[1] ? '0 : bus.req_a_i;
    end
  end

  assign bus.req_ready_o  = (state_q == ST_IDLE) && !bus.kill_i;
  assign bus.resp_valid_o = (state_q == ST_DONE);
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.result_o     = result_q;
  assign bus.resp_tag_o   = tag_q;
  assign accept           = bus.req_valid_i && bus.req_ready_o;

  // ---------------- multiply step ----------------
  logic [MUL_STEP-1:0] digit;
  logic [W2-1:0]       partial, acc_sum, prod_fix;
  logic [XLEN-1:0]     sh_rest, mul_res;
  logic                mul_last;

  always_comb begin
    digit    = sh_q[MUL_STEP-1:0];
    partial  = wide_q * {{(W2-MUL_STEP){1'b0}}, digit};
    acc_sum  = acc_q + partial;
    // Sign fix folded into the last iteration so no extra cycle is needed.
    prod_fix = neg_q ? -acc_sum : acc_sum;
    mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[W2-1:XLEN];
    sh_rest  = sh_q >> MUL_STEP;
`ifdef MDU_EARLY_OUT_EN
    mul_last = (cnt_q == CW'(NM - 1)) || (sh_rest == '0);
`else
    mul_last = (cnt_q == CW'(NM - 1));
`endif
  end

  // ---------------- divide step ----------------
  logic [XLEN:0]   rem_w;
  logic [XLEN-1:0] quo_w, q_fix, r_fix, div_res;
  logic            div_last;

  always_comb begin
    rem_w = {1'b0, acc_q[XLEN-1:0]};
    quo_w = sh_q;
    for (int unsigned i = 0; i < DIV_STEP; i++) begin
      rem_w = {rem_w[XLEN-1:0], quo_w[XLEN-1]};
      quo_w = {quo_w[XLEN-2:0], 1'b0};
      if (rem_w >= {1'b0, wide_q[XLEN-1:0]}) begin
        rem_w    = rem_w - {1'b0, wide_q[XLEN-1:0]};
        quo_w[0] = 1'b1;
      end
    end
    q_fix    = neg_q ? -quo_w : quo_w;
    r_fix    = sa_q ? -rem_w[XLEN-1:0] : rem_w[XLEN-1:0];
    div_res  = op_q[1] ? r_fix : q_fix;
    div_last = (cnt_q == CW'(ND - 1));
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    result_d = result_q;
    sh_d     = sh_q;
    wide_d   = wide_q;
    acc_d    = acc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = bus.req_op_i;
          tag_d  = bus.req_tag_i;
          neg_d  = sa_in ^ sb_in;
          sa_d   = sa_in;
          cnt_d  = '0;
          acc_d  = '0;
          sh_d   = is_div_in ? ma_in : mb_in;
          wide_d = {{XLEN{1'b0}}, (is_div_in ? mb_in : ma_in)};
          if (is_div_in && (div_zero || div_ovf)) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end else if (is_div_in) begin
            state_d = ST_DIV;
          end else begin
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (bus.kill_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d  = acc_sum;
          wide_d = wide_q << MUL_STEP;
          sh_d   = sh_rest;
          cnt_d  = cnt_q + CW'(1);
          if (mul_last) begin
            result_d = mul_res;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DIV: begin
        if (bus.kill_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = {{XLEN{1'b0}}, rem_w[XLEN-1:0]};
          sh_d  = quo_w;
          cnt_d = cnt_q + CW'(1);
          if (div_last) begin
            result_d = div_res;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A kill wins over a coincident handshake: the result is dropped.
        if (bus.kill_i || bus.resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      result_q <= '0;
      sh_q     <= '0;
      wide_q   <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      result_q <= result_d;
      sh_q     <= sh_d;
      wide_q   <= wide_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the RV32M/RV64M execute stage.
- Supersedes the separate fixed-width mult_unit/div_unit pair with one block: shared operand/tag capture, valid/ready handshakes on request and response, pipeline kill, configurable bits-per-cycle for multiply and divide, and RISC-V-exact corner cases.
- Sits beside the ALU. The execute stage stalls while a request is outstanding and steers result_o into the EX/MEM register.

Parameters:
- XLEN, 32: operand/result width; 32 or 64.
- MUL_STEP, 4: multiplier bits retired per iteration; must divide XLEN.
- DIV_STEP, 1: quotient bits retired per iteration; 1 or 2; must divide XLEN.
- TAG_W, 5: width of the opaque tag (destination register address) carried with the request.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit can accept a request
- req_op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_a_i  in  XLEN  rs1 operand
- req_b_i  in  XLEN  rs2 operand
- req_tag_i  in  TAG_W  tag
- kill_i  in  1  flush; abandons any in-flight or completed operation
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer accepts result
- result_o  out  XLEN  result
- resp_tag_o  out  TAG_W  tag of the result
- busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni.
- Reset values: state IDLE; req_ready_o=1; resp_valid_o=0; busy_o=0; result_o=0; resp_tag_o=0.
- FSM states: IDLE, MUL, DIV, DONE.
- req_ready_o = (state==IDLE) && !kill_i.
- Accept occurs on a rising edge with req_valid_i && req_ready_o. On accept, capture the operand magnitudes, sign flags, op and tag.
- IDLE -> MUL for ops 0xx.
- IDLE -> DIV for ops 1xx, except the special cases below.
- Special cases go IDLE -> DONE directly; resp_valid_o is visible in the cycle after the accepting edge:
  - Divide by zero (b==0): DIV/DIVU result all-ones; REM/REMU result = a.
  - Signed overflow (DIV/REM with a = most-negative and b = -1): DIV result = a; REM result = 0.
- MUL: NM = XLEN/MUL_STEP iterations, one per edge. Operands are unsigned magnitudes; the 2*XLEN product is negated at the end if the signs differ.
  - Sign of a: MULH and MULHSU treat a as signed.
  - Sign of b: only MULH treats b as signed.
  - MUL returns product[XLEN-1:0]; the others return product[2*XLEN-1:XLEN].
- DIV: ND = XLEN/DIV_STEP restoring iterations on magnitudes.
  - Quotient is negated iff the signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Latency: resp_valid_o rises exactly NM (or ND) edges after the accepting edge. Defaults: MUL 8, DIV 32. The final sign fix happens on the last iteration edge, never as an extra cycle.
- DONE holds result_o and resp_tag_o stable while resp_valid_o && !resp_ready_i.
- DONE -> IDLE on the handshake edge. The next accept is possible one cycle later; there is no overlap.
- kill_i in MUL, DIV or DONE: next edge -> IDLE, resp_valid_o=0, and no response is ever produced for that op.
- kill_i in IDLE: blocks the accept.
- kill_i coincident with resp_ready_i in DONE: treated as a kill; the result is dropped.
- Reset asserted mid-operation: immediate return to IDLE with the reset values above.
- Inputs are sampled only at accept; later changes to req_* are ignored.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: MUL leaves for DONE at the edge where the remaining unprocessed multiplier magnitude bits are all zero, minimum 1 iteration.
  - Example: a=3, b=5, MUL_STEP=4 gives resp_valid one edge after accept.
  - Results are bit-identical to the fixed-latency path.
- Undefined: MUL always takes exactly NM iterations. DIV is unaffected in both cases.

Test Plan:
1. MUL a=0x0000_0007, b=0xFFFF_FFFD (-3), tag=5 -> result 0xFFFF_FFEB, tag 5. resp_valid exactly 8 edges after accept (early-out off).
2. MULH a=0x8000_0000, b=0x8000_0000 -> 0x4000_0000. MULHU same operands -> 0x4000_0000. MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> 0xFFFF_FFFF.
3. DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF. DIVU 100/7 -> 14, valid 32 edges after accept.
4. Corner cases:
   - DIV 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 5.
   - DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM same operands -> 0. All with valid one cycle after accept.
5. Hold resp_ready_i=0 for 10 cycles in DONE -> result/tag stable, req_ready_o=0. Raise ready -> IDLE, req_ready_o=1 the following cycle.
6. kill_i mid-DIV (iteration 10) and in DONE -> no resp_valid_o. Next request DIVU 9/3 returns 3 correctly. Assert rst_ni low mid-MUL -> all outputs at reset values immediately.
